// File: rtl/sync_transmitter.sv
// -----------------------------------------------------------------------------
// sync_transmitter
// Sending end of a NoC clock-domain-crossing link. Flits from the local
// producer are buffered in a small FIFO. Each flit is then sent across the
// link with a two-phase toggle handshake: req changes level once per flit,
// and data_out is held until the synchronized ack level equals req.
//
// Ports
//   clock      in   single clock, all state updates on posedge
//   reset      in   synchronous active-high reset
//   data_in    in   flit from the local producer
//   valid_in   in   active-low valid for data_in
//   chnl_stop  out  registered back-pressure, 1 = FIFO full, writes ignored
//   req        out  registered link request, toggles once per flit
//   ack        in   asynchronous link acknowledge from the receiver
//   data_out   out  registered link data, stable until ack matches req
// -----------------------------------------------------------------------------
module sync_transmitter #(
  parameter int DATA_WIDTH  = 34,
  parameter int BUFFER_SIZE = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  chnl_stop,
  output logic                  req,
  input  logic                  ack,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETUP    = 2'd1,
    ST_WAIT_ACK = 2'd2
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_ack_sync;
  logic [DATA_WIDTH-1:0]   r_mem [BUFFER_SIZE];
  logic [PTR_W-1:0]        r_wr_ptr;
  logic [PTR_W-1:0]        r_rd_ptr;
  logic [CNT_W-1:0]        r_count;

  logic                    w_ack_s;
  logic                    w_wr_en;
  logic                    w_pop;
  logic [CNT_W-1:0]        w_next_count;

  // Only the last synchronizer stage is safe to use in this domain.
  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // A write is taken only when the registered back-pressure is low.
  assign w_wr_en = ~valid_in & ~chnl_stop;

  // The FSM pops the FIFO head only from IDLE.
  assign w_pop   = (r_state == ST_IDLE) && (r_count != {CNT_W{1'b0}});

  // Next FIFO occupancy; a write and a pop in the same cycle cancel out.
  always_comb begin
    w_next_count = r_count;
    case ({w_wr_en, w_pop})
      2'b10:   w_next_count = r_count + CNT_W'(1);
      2'b01:   w_next_count = r_count - CNT_W'(1);
      default: w_next_count = r_count;
    endcase
  end

  // Shift the asynchronous ack through the synchronizer chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ack_sync <= {SYNC_STAGES{1'b0}};
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], ack};
    end
  end

  // FIFO storage; contents need no reset because count guards every read.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and back-pressure flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr  <= {PTR_W{1'b0}};
      r_rd_ptr  <= {PTR_W{1'b0}};
      r_count   <= {CNT_W{1'b0}};
      chnl_stop <= 1'b0;
    end else begin
      // Power-of-two depth lets the pointers wrap by natural overflow.
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count   <= w_next_count;
      chnl_stop <= (w_next_count == CNT_W'(BUFFER_SIZE));
    end
  end

  // Link FSM: load data_out, then toggle req a cycle later, then wait for ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      req      <= 1'b0;
      data_out <= {DATA_WIDTH{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            data_out <= r_mem[r_rd_ptr];
            r_state  <= ST_SETUP;
          end else begin
            r_state  <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          // data_out has had a full cycle to settle before this req edge.
          req     <= ~req;
          r_state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Level match, not edge: completion is the ack level catching up.
          if (w_ack_s == req) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_WAIT_ACK;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sync_transmitter.sv
// -----------------------------------------------------------------------------
// tb_sync_transmitter
// Scoreboard bench for sync_transmitter. Stimulus pushes the expected flits
// into a queue. A forked monitor pops one entry on every req level change
// and compares it with data_out. The link receiver is modelled as a
// req-history shift register, so ack either follows req after a chosen delay
// or is frozen at a chosen level.
// -----------------------------------------------------------------------------
module tb_sync_transmitter;

  localparam int DW = 34;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b1;
  logic          chnl_stop;
  logic          req;
  logic          ack;
  logic [DW-1:0] data_out;

  int            n_tests = 0;
  int            n_fail = 0;
  int            n_toggle = 0;
  logic [DW-1:0] sb_q[$];

  int            ack_dly = 2;
  logic          ack_mode = 1'b1;   // 0: loopback, 1: frozen at ack_hold
  logic          ack_hold = 1'b1;
  logic [15:0]   r_hist = '0;

  sync_transmitter #(.DATA_WIDTH(DW), .BUFFER_SIZE(4), .SYNC_STAGES(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .chnl_stop (chnl_stop),
    .req       (req),
    .ack       (ack),
    .data_out  (data_out)
  );

  always #5 clock = ~clock;

  // Receiver model: req history, cleared together with the transmitter.
  always @(posedge clock) begin
    if (reset) r_hist <= '0;
    else       r_hist <= {r_hist[14:0], req};
  end

  always_comb begin
    ack = ack_mode ? ack_hold : r_hist[ack_dly-1];
  end

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_dat(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Present a flit for exactly one edge, whether or not it is taken.
  task automatic send_once(input logic [DW-1:0] d);
    data_in  = d;
    valid_in = 1'b0;
    tick(1);
    valid_in = 1'b1;
  endtask

  // Hold a flit until an edge sees chnl_stop low, as a producer must.
  task automatic send_hold(input logic [DW-1:0] d);
    logic stop;
    logic ok;
    ok       = 1'b0;
    data_in  = d;
    valid_in = 1'b0;
    for (int i = 0; i < 200; i++) begin
      stop = chnl_stop;
      tick(1);
      if (!stop) begin
        ok = 1'b1;
        break;
      end
    end
    valid_in = 1'b1;
    check_bit("send_hold_accepted", ok, 1'b1);
  endtask

  task automatic wait_toggles(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_toggle >= target) break;
      tick(1);
    end
    check_int("req_toggle_count", n_toggle, target);
  endtask

  // Monitor: every req level change presents one flit on data_out.
  task automatic monitor();
    logic          prev_req;
    logic          prev_ack_s;
    logic [DW-1:0] prev_do;
    logic [DW-1:0] exp;
    prev_req   = 1'b0;
    prev_ack_s = 1'b0;
    prev_do    = '0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if (req !== prev_req) begin
          n_toggle++;
          if (sb_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL flit_unexpected: got 0x%0h with no flit expected", data_out);
          end else begin
            exp = sb_q.pop_front();
            check_dat("flit_order", data_out, exp);
          end
        end
        if (data_out !== prev_do) begin
          check_bit("data_stable_while_pending", prev_req == prev_ack_s, 1'b1);
        end
      end
      prev_req   = req;
      prev_do    = data_out;
      prev_ack_s = dut.w_ack_s;
    end
  endtask

  initial begin
    int base;
    logic stop;
    logic ok;

    fork
      monitor();
    join_none

    // Reset: 3 cycles with valid_in=0 and ack=1.
    data_in  = 34'h1_2345_6789;
    valid_in = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_bit("rst_req", req, 1'b0);
    check_bit("rst_stop", chnl_stop, 1'b0);
    check_dat("rst_data_out", data_out, 34'h0);
    check_bit("rst_ack_sync", |dut.r_ack_sync, 1'b0);
    reset    = 1'b0;
    valid_in = 1'b1;
    ack_mode = 1'b0;
    tick(4);
    check_dat("rst_no_write", data_out, 34'h0);
    check_int("rst_no_toggle", n_toggle, 0);

    // Single flit, ack looped back through 2 flops.
    ack_dly = 2;
    sb_q.push_back(34'h2_AAAA_5555);
    send_once(34'h2_AAAA_5555);
    check_dat("single_no_bypass", data_out, 34'h0);
    tick(1);
    check_dat("single_data_out", data_out, 34'h2_AAAA_5555);
    check_bit("single_req_before", req, 1'b0);
    tick(1);
    check_bit("single_req_after", req, 1'b1);
    tick(8);
    check_bit("single_ack_s", dut.w_ack_s, 1'b1);
    check_int("single_one_edge", n_toggle, 1);

    // Stream of 8 flits 1..8, ack after 5 cycles.
    ack_dly = 5;
    base = n_toggle;
    for (int v = 1; v <= 8; v++) begin
      sb_q.push_back(DW'(v));
      send_hold(DW'(v));
    end
    wait_toggles(base + 8, 400);
    tick(20);
    check_int("stream_exact_8", n_toggle, base + 8);
    check_dat("stream_last", data_out, 34'h8);
    check_int("stream_sb_empty", sb_q.size(), 0);

    // Full condition: stall one flit in WAIT_ACK, then fill the FIFO.
    ack_hold = ack;
    ack_mode = 1'b1;
    base = n_toggle;
    sb_q.push_back(34'h100);
    send_hold(34'h100);
    tick(3);
    check_int("full_stalled_flit", n_toggle, base + 1);
    for (int i = 1; i <= 4; i++) begin
      check_bit("full_stop_pre", chnl_stop, 1'b0);
      sb_q.push_back(DW'(34'h200 + i));
      send_once(DW'(34'h200 + i));
    end
    check_bit("full_stop_set", chnl_stop, 1'b1);
    send_once(34'h205);
    check_bit("full_drop5_stop", chnl_stop, 1'b1);
    send_once(34'h206);
    check_bit("full_drop6_stop", chnl_stop, 1'b1);

    // Release ack while holding flit 5: one pop frees one slot, refilled at once.
    sb_q.push_back(34'h205);
    data_in  = 34'h205;
    valid_in = 1'b0;
    ack_hold = ~ack_hold;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      stop = chnl_stop;
      tick(1);
      if (!stop) begin
        ok = 1'b1;
        break;
      end
    end
    valid_in = 1'b1;
    check_bit("held_flit_accepted", ok, 1'b1);
    check_bit("refill_stop_again", chnl_stop, 1'b1);
    tick(1);
    check_bit("refill_stop_held", chnl_stop, 1'b1);

    // Drain with loopback ack; 7 writes through 4 slots exercise the wrap.
    ack_dly  = 3;
    ack_mode = 1'b0;
    sb_q.push_back(34'h206);
    send_hold(34'h206);
    wait_toggles(base + 7, 400);
    check_int("wrap_sb_empty", sb_q.size(), 0);

    // Reset while in WAIT_ACK with req=1.
    tick(20);
    ack_hold = ack;
    ack_mode = 1'b1;
    base = n_toggle;
    sb_q.push_back(34'h300);
    send_hold(34'h300);
    tick(3);
    check_bit("pre_rst_req", req, 1'b1);
    send_once(34'h301);
    send_once(34'h302);
    reset    = 1'b1;
    ack_mode = 1'b0;
    tick(1);
    check_bit("midrst_req", req, 1'b0);
    check_dat("midrst_data_out", data_out, 34'h0);
    check_bit("midrst_stop", chnl_stop, 1'b0);
    tick(1);
    reset = 1'b0;
    sb_q.delete();
    tick(10);
    check_int("midrst_fifo_empty", n_toggle, base + 1);
    check_dat("midrst_no_pop", data_out, 34'h0);

    sb_q.push_back(34'h3_0000_0001);
    send_hold(34'h3_0000_0001);
    tick(2);
    check_bit("post_rst_req", req, 1'b1);
    sb_q.push_back(34'h3_0000_0002);
    send_hold(34'h3_0000_0002);
    wait_toggles(base + 3, 100);
    check_bit("post_rst_req_back", req, 1'b0);
    check_int("post_rst_sb_empty", sb_q.size(), 0);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
